// File: rtl/mul8_pkg.sv
// mul8_pkg: shared state encoding and iteration count for the 8x8 shift-add multiplier.
package mul8_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam int MUL8_ITER = 8;
endpackage

// File: rtl/eight_bit_adder.sv
// eight_bit_adder: 8-bit ripple-carry adder built from full-adder cells.
module eight_bit_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] so,
    output logic       co
);
    logic [8:0] c;
    assign c[0] = ci;
    assign co = c[8];
    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign so[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
endmodule

// File: rtl/shift_add_mul8.sv
// shift_add_mul8: iterative 8x8 unsigned multiplier, one add-and-shift step per clock
// through a single eight_bit_adder, with start/busy/done handshake.
module shift_add_mul8
    import mul8_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);
    logic [1:0] state;
    logic [7:0] m;
    logic [7:0] acc;
    logic [7:0] q;
    logic [3:0] cnt;
    logic [7:0] s;
    logic       c;
    logic       accept;
    logic [15:0] step;

    eight_bit_adder u_add (
        .a  (acc),
        .b  (q[0] ? m : 8'h00),
        .ci (1'b0),
        .so (s),
        .co (c)
    );

    // carry becomes the new acc msb, so the 17-bit sum shifted right never loses a bit
    assign step   = {c, s, q[7:1]};
    assign accept = start && state != ST_RUN;
    assign busy   = state == ST_RUN;
    assign done   = state == ST_DONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            m       <= '0;
            acc     <= '0;
            q       <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (accept) begin
            state <= ST_RUN;
            m     <= a;
            q     <= b;
            acc   <= '0;
            cnt   <= '0;
        end else if (state == ST_RUN) begin
            {acc, q} <= step;
            cnt      <= cnt + 4'd1;
            if (cnt == 4'(MUL8_ITER - 1)) begin
                state   <= ST_DONE;
                product <= step;
            end
        end else begin
            state <= ST_IDLE;
        end
    end
endmodule
